// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, transmitter FSM states and frame sizing.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } uart_state_e;

    // Frame length in clock cycles, start bit through last stop bit.
    function automatic int unsigned frame_len(
        input int unsigned data_bits,
        input int unsigned parity,
        input int unsigned stop_bits,
        input int unsigned clks_per_bit
    );
        int unsigned bits;
        bits = 1 + data_bits + stop_bits;
        if (parity != 0) begin
            bits = bits + 1;
        end
        return clks_per_bit * bits;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: flags the last clock cycle of each serial bit.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    output logic bit_end_o
);

    generate
        if (CLKS_PER_BIT == 1) begin : g_direct
            // Clock already runs at the baud rate: every cycle ends a bit.
            logic unused_ok;
            assign unused_ok = ^{clk_i, rst_ni, clr_i};
            assign bit_end_o = 1'b1;
        end else begin : g_div
            localparam int CNT_W = $clog2(CLKS_PER_BIT);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

            logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;

            assign bit_end_o = (clk_cnt_q == CNT_LAST);

            always_comb begin
                clk_cnt_d = clk_cnt_q + CNT_W'(1);
                if (clr_i || bit_end_o) begin
                    clk_cnt_d = '0;
                end
            end

            always_ff @(posedge clk_i) begin
                if (!rst_ni) begin
                    clk_cnt_q <= '0;
                end else begin
                    clk_cnt_q <= clk_cnt_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start, DATA_BITS LSB-first, optional parity,
// 1 or 2 stop bits; accepts back-to-back words with no idle gap.
module uart_tx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic                 tx_clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [DATA_BITS-1:0] data_in,
    output logic                 data_out,
    output logic                 ready,
    output logic                 start,
    output logic                 busy,
    output logic                 done
);

    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    uart_state_e          state_q, state_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic                 stop_idx_q, stop_idx_d;
    logic                 par_q, par_d;
    logic                 data_out_q, data_out_d;
    logic                 done_q, done_d;

    logic bit_end;
    logic cnt_clr;
    logic last_stop;
    logic accept;

    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk_i    (tx_clk),
        .rst_ni   (rst),
        .clr_i    (cnt_clr),
        .bit_end_o(bit_end)
    );

    assign cnt_clr   = (state_q == ST_IDLE);
    assign last_stop = (state_q == ST_STOP) && bit_end && (stop_idx_q == STOP_LAST);
    assign ready     = (state_q == ST_IDLE) || last_stop;
    assign accept    = en && ready;

    assign data_out = data_out_q;
    assign start    = (state_q == ST_START);
    assign busy     = (state_q != ST_IDLE);
    assign done     = done_q;

    // data_out is registered, so each branch loads the level of the bit about to begin.
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_idx_d  = bit_idx_q;
        stop_idx_d = stop_idx_q;
        par_d      = par_q;
        data_out_d = data_out_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                data_out_d = 1'b1;
            end
            ST_START: begin
                if (bit_end) begin
                    state_d    = ST_DATA;
                    bit_idx_d  = '0;
                    data_out_d = shreg_q[0];
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    shreg_d = shreg_q >> 1;
                    if (bit_idx_q == IDX_LAST) begin
                        if (PARITY != PAR_NONE) begin
                            state_d    = ST_PARITY;
                            data_out_d = par_q;
                        end else begin
                            state_d    = ST_STOP;
                            stop_idx_d = 1'b0;
                            data_out_d = 1'b1;
                        end
                    end else begin
                        bit_idx_d  = bit_idx_q + IDX_W'(1);
                        data_out_d = shreg_q[1];
                    end
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d    = ST_STOP;
                    stop_idx_d = 1'b0;
                    data_out_d = 1'b1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    if (stop_idx_q == STOP_LAST) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        stop_idx_d = 1'b1;
                    end
                    data_out_d = 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                data_out_d = 1'b1;
            end
        endcase

        // Acceptance overrides the IDLE hold or the return from the last stop bit.
        if (accept) begin
            state_d    = ST_START;
            shreg_d    = data_in;
            par_d      = (^data_in) ^ (PARITY == PAR_ODD);
            data_out_d = 1'b0;
        end
    end

    always_ff @(posedge tx_clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            par_q      <= 1'b0;
            data_out_q <= 1'b1;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            stop_idx_q <= stop_idx_d;
            par_q      <= par_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
        end
    end

endmodule

// File: tb/tb_uart_tx_param.sv
// Self-checking bench: four transmitter configurations against a frame-level model.
module tb_uart_tx_param;

    localparam int N = 4;

    logic tx_clk = 1'b0;
    always #5 tx_clk = ~tx_clk;

    logic       rst_v [N];
    logic       en_v  [N];
    logic [7:0] din_v [N];
    logic       dout  [N];
    logic       rdy   [N];
    logic       st    [N];
    logic       bsy   [N];
    logic       dn    [N];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model: the whole expected line waveform of the frame in flight.
    bit fb     [N][64];
    int flen   [N];
    int pos    [N];
    bit act    [N];
    bit mdone  [N];
    bit chk_on [N];

    uart_tx_param u_d0 (
        .tx_clk(tx_clk), .rst(rst_v[0]), .en(en_v[0]), .data_in(din_v[0]),
        .data_out(dout[0]), .ready(rdy[0]), .start(st[0]), .busy(bsy[0]), .done(dn[0])
    );
    uart_tx_param #(.DATA_BITS(7), .PARITY(2)) u_d1 (
        .tx_clk(tx_clk), .rst(rst_v[1]), .en(en_v[1]), .data_in(din_v[1][6:0]),
        .data_out(dout[1]), .ready(rdy[1]), .start(st[1]), .busy(bsy[1]), .done(dn[1])
    );
    uart_tx_param #(.DATA_BITS(7), .PARITY(1)) u_d2 (
        .tx_clk(tx_clk), .rst(rst_v[2]), .en(en_v[2]), .data_in(din_v[2][6:0]),
        .data_out(dout[2]), .ready(rdy[2]), .start(st[2]), .busy(bsy[2]), .done(dn[2])
    );
    uart_tx_param #(.STOP_BITS(2), .CLKS_PER_BIT(4)) u_d3 (
        .tx_clk(tx_clk), .rst(rst_v[3]), .en(en_v[3]), .data_in(din_v[3]),
        .data_out(dout[3]), .ready(rdy[3]), .start(st[3]), .busy(bsy[3]), .done(dn[3])
    );

    function automatic int cfg_db(input int i);
        return (i == 1 || i == 2) ? 7 : 8;
    endfunction
    function automatic int cfg_par(input int i);
        return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
    endfunction
    function automatic int cfg_sb(input int i);
        return (i == 3) ? 2 : 1;
    endfunction
    function automatic int cfg_cpb(input int i);
        return (i == 3) ? 4 : 1;
    endfunction

    task automatic chk(input string nm, input int i, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s inst%0d cyc %0d got %b exp %b", nm, i, cyc, got, exp);
        end
    endtask

    task automatic chk_vec(input string nm, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", nm, got, exp);
        end
    endtask

    task automatic build(input int i, input logic [7:0] w);
        bit seq [16];
        int nb;
        bit p;
        nb = 0;
        p  = 1'b0;
        seq[nb] = 1'b0; nb++;
        for (int b = 0; b < cfg_db(i); b++) begin
            seq[nb] = w[b]; nb++;
            p = p ^ w[b];
        end
        if (cfg_par(i) != 0) begin
            seq[nb] = (cfg_par(i) == 1) ? !p : p; nb++;
        end
        for (int s = 0; s < cfg_sb(i); s++) begin
            seq[nb] = 1'b1; nb++;
        end
        flen[i] = 0;
        for (int k = 0; k < nb; k++) begin
            for (int c = 0; c < cfg_cpb(i); c++) begin
                fb[i][flen[i]] = seq[k];
                flen[i]++;
            end
        end
        pos[i] = 0;
        act[i] = 1'b1;
    endtask

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            bit rm;
            rm = !act[i] || (pos[i] == flen[i] - 1);
            if (!rst_v[i]) begin
                act[i]    = 1'b0;
                mdone[i]  = 1'b0;
                chk_on[i] = 1'b1;
            end else begin
                mdone[i] = 1'b0;
                if (act[i]) begin
                    if (pos[i] == flen[i] - 1) begin
                        act[i]   = 1'b0;
                        mdone[i] = 1'b1;
                    end else begin
                        pos[i]++;
                    end
                end
                if (en_v[i] && rm) build(i, din_v[i]);
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < N; i++) begin
            if (chk_on[i]) begin
                chk("data_out", i, dout[i], act[i] ? fb[i][pos[i]] : 1'b1);
                chk("start",    i, st[i],   act[i] && (pos[i] < cfg_cpb(i)));
                chk("busy",     i, bsy[i],  act[i]);
                chk("done",     i, dn[i],   mdone[i]);
                chk("ready",    i, rdy[i],  !act[i] || (pos[i] == flen[i] - 1));
            end
        end
    endtask

    task automatic cycle();
        @(posedge tx_clk);
        cyc++;
        model_step();
        @(negedge tx_clk);
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    // Accepts w, then drives w2 on data_in; en stays high for `hold` further edges.
    task automatic accept_rec(input int i, input logic [7:0] w, input logic [7:0] w2,
                              input int hold, input int n,
                              output logic [127:0] vdo, output logic [127:0] vst,
                              output logic [127:0] vbs, output logic [127:0] vdn);
        vdo = '0; vst = '0; vbs = '0; vdn = '0;
        en_v[i]  = 1'b1;
        din_v[i] = w;
        cycle();
        din_v[i] = w2;
        if (hold == 0) en_v[i] = 1'b0;
        for (int j = 0; j < n; j++) begin
            vdo[j] = dout[i];
            vst[j] = st[i];
            vbs[j] = bsy[i];
            vdn[j] = dn[i];
            if (j < n - 1) begin
                cycle();
                if (j + 1 == hold) en_v[i] = 1'b0;
            end
        end
        en_v[i] = 1'b0;
    endtask

    initial begin
        logic [127:0] vdo, vst, vbs, vdn;
        for (int i = 0; i < N; i++) begin
            rst_v[i] = 1'b0;
            en_v[i]  = 1'b0;
            din_v[i] = '0;
        end
        idle(2);
        for (int i = 0; i < N; i++) begin
            chk("rst_data_out", i, dout[i], 1'b1);
            chk("rst_busy",     i, bsy[i],  1'b0);
            chk("rst_start",    i, st[i],   1'b0);
            chk("rst_done",     i, dn[i],   1'b0);
            chk("rst_ready",    i, rdy[i],  1'b1);
            rst_v[i] = 1'b1;
        end
        idle(2);

        // 8N1 0xA5; data_in changes after acceptance
        accept_rec(0, 8'hA5, 8'h5A, 0, 11, vdo, vst, vbs, vdn);
        chk_vec("a5_line",  vdo, 128'h74A);
        chk_vec("a5_start", vst, 128'h001);
        chk_vec("a5_busy",  vbs, 128'h3FF);
        chk_vec("a5_done",  vdn, 128'h400);
        idle(2);

        // 7E1 and 7O1 with 0x35
        accept_rec(1, 8'h35, 8'h00, 0, 11, vdo, vst, vbs, vdn);
        chk_vec("even_line", vdo, 128'h66A);
        chk_vec("even_done", vdn, 128'h400);
        accept_rec(2, 8'h35, 8'h00, 0, 11, vdo, vst, vbs, vdn);
        chk_vec("odd_line", vdo, 128'h76A);
        chk_vec("odd_done", vdn, 128'h400);
        idle(2);

        // CLKS_PER_BIT=4, two stop bits, 0x00
        accept_rec(3, 8'h00, 8'hFF, 0, 45, vdo, vst, vbs, vdn);
        chk_vec("div_line",  vdo, 128'h1FF << 36);
        chk_vec("div_start", vst, 128'hF);
        chk_vec("div_busy",  vbs, (128'h1 << 44) - 128'h1);
        chk_vec("div_done",  vdn, 128'h1 << 44);
        idle(2);

        // back-to-back 0x12 then 0x34 with en held
        accept_rec(0, 8'h12, 8'h34, 10, 21, vdo, vst, vbs, vdn);
        chk_vec("b2b_line",  vdo, 128'h19A224);
        chk_vec("b2b_start", vst, 128'h401);
        chk_vec("b2b_busy",  vbs, 128'hFFFFF);
        chk_vec("b2b_done",  vdn, 128'h100400);
        idle(2);

        // reset during data bit 3 of 0xFF
        en_v[0]  = 1'b1;
        din_v[0] = 8'hFF;
        cycle();
        en_v[0]  = 1'b0;
        din_v[0] = 8'h00;
        idle(4);
        chk("mid_busy", 0, bsy[0], 1'b1);
        rst_v[0] = 1'b0;
        cycle();
        rst_v[0] = 1'b1;
        chk("abort_data_out", 0, dout[0], 1'b1);
        chk("abort_busy",     0, bsy[0],  1'b0);
        chk("abort_start",    0, st[0],   1'b0);
        chk("abort_ready",    0, rdy[0],  1'b1);
        chk("abort_done",     0, dn[0],   1'b0);
        idle(12);
        accept_rec(0, 8'h01, 8'h00, 0, 11, vdo, vst, vbs, vdn);
        chk_vec("post_rst_line", vdo, 128'h602);
        chk_vec("post_rst_done", vdn, 128'h400);
        idle(2);

        // en while busy with other data is ignored
        accept_rec(0, 8'h5A, 8'h0F, 3, 11, vdo, vst, vbs, vdn);
        chk_vec("ign_line",  vdo, 128'h6B4);
        chk_vec("ign_busy",  vbs, 128'h3FF);
        chk_vec("ign_start", vst, 128'h001);
        idle(6);
        chk("ign_no_frame", 0, bsy[0], 1'b0);

        // back-to-back on the divided clock
        accept_rec(3, 8'hC3, 8'h3C, 44, 89, vdo, vst, vbs, vdn);
        chk_vec("div_b2b_start", vst, 128'hF | (128'hF << 44));
        chk_vec("div_b2b_busy",  vbs, (128'h1 << 88) - 128'h1);
        chk_vec("div_b2b_done",  vdn, (128'h1 << 44) | (128'h1 << 88));
        idle(2);

        // reset and en together: nothing accepted
        rst_v[0] = 1'b0;
        en_v[0]  = 1'b1;
        din_v[0] = 8'hFF;
        cycle();
        rst_v[0] = 1'b1;
        en_v[0]  = 1'b0;
        chk("rst_en_busy",     0, bsy[0],  1'b0);
        chk("rst_en_data_out", 0, dout[0], 1'b1);
        idle(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_param.md
Name: uart_tx_param

Overview:
Parametrised successor to the fixed 8N1 UART transmitter. It serialises one parallel word per frame: a start bit, DATA_BITS data bits LSB-first, optional parity, then 1 or 2 stop bits. It runs either directly on a baud-rate clock (CLKS_PER_BIT=1) or on a faster system clock with an internal bit-period divider. It also accepts back-to-back words with no idle gap between frames.

Parameters:
DATA_BITS, 8, payload width; legal 5..9.
PARITY, 0, 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, number of stop bits; legal 1 or 2.
CLKS_PER_BIT, 1, tx_clk cycles per serial bit; legal ≥1 (1 = tx_clk is the baud clock).

Ports:
tx_clk  in  1  single clock for all logic
rst  in  1  synchronous, active-low reset (sampled on rising tx_clk)
en  in  1  transmit request; data_in is accepted when en && ready at a rising edge
data_in  in  DATA_BITS  word to send; sampled only on acceptance
data_out  out  1  serial line, idles high; registered
ready  out  1  combinational; 1 in IDLE, or in the final tx_clk cycle of the last stop bit
start  out  1  high for the full start-bit period
busy  out  1  high from the first start-bit cycle through the last stop-bit cycle
done  out  1  one-cycle pulse in the first cycle after the last stop bit completes

Behaviour:
- Reset (rst=0 at an edge): next cycle data_out=1, busy=0, start=0, done=0, ready=1; state=IDLE, counters cleared. Reset mid-frame aborts the frame. The line returns high next cycle. done does not pulse.
- FSM states: IDLE -> START -> DATA -> (PARITY if PARITY≠0) -> STOP -> IDLE, or STOP -> START on back-to-back acceptance.
- Each state holds for CLKS_PER_BIT cycles, counted by bit-period counter clk_cnt, width $clog2(CLKS_PER_BIT) (min 1). DATA repeats DATA_BITS times, indexed by bit_idx. STOP repeats STOP_BITS times.
- Acceptance at edge N (en && ready): data_in is latched into a shift register. Parity is computed from that latched value. From cycle N+1: data_out=0, start=1, busy=1.
- Data bits: data_out = shreg[0]; shift right at each bit boundary.
- Parity bit: even = XOR of all data bits; odd = its inverse.
- Stop bits: data_out=1.
- Frame length L = CLKS_PER_BIT*(1+DATA_BITS+(PARITY≠0)+STOP_BITS) cycles.
- done pulses at cycle N+1+L. busy is 0 in that cycle unless a back-to-back word was accepted.
- Back-to-back: if en && ready during the last stop-bit cycle, the next frame's start bit begins in the very next cycle. done and start are both 1 in that cycle, and busy stays 1 continuously.
- en when ready=0: ignored, no queueing. en held high continuously sends back-to-back frames, each sampling data_in at its own acceptance edge.
- Changes to data_in after acceptance have no effect on the frame in flight.
- Simultaneous reset and en: reset wins; nothing is accepted.

Decomposition:
- Shared package uart_pkg holds:
  - parity encodings PAR_NONE=0, PAR_ODD=1, PAR_EVEN=2
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP)
  - a function computing frame length from the parameters
- Sub-module uart_baud_cnt (bit-period counter): outputs bit_end when clk_cnt==CLKS_PER_BIT-1. Reset and restart come from the FSM. For CLKS_PER_BIT=1, bit_end is tied high. The same counter is reused by the future RX block.

Test Plan:
- Defaults (8N1, CLKS_PER_BIT=1), accept 0xA5 at edge N -> data_out over cycles N+1..N+10 = 0,1,0,1,0,0,1,0,1,1; start=1 only at N+1; busy=1 for N+1..N+10; done=1 only at N+11.
- DATA_BITS=7, PARITY=2, word 0x35 -> data bits 1,0,1,0,1,1,0 then parity 0, stop 1. With PARITY=1, same word -> parity bit 1.
- CLKS_PER_BIT=4, STOP_BITS=2, word 0x00 -> start 4 cycles low, 32 cycles low, 8 cycles high; done 45 cycles after acceptance.
- Back-to-back: en held high, words 0x12 then 0x34 (8N1, CLKS=1) -> second start bit immediately follows first stop bit; done and start coincide at N+11; busy never drops; second done at N+21.
- Reset mid-frame: rst=0 at data bit 3 of 0xFF -> next cycle data_out=1, busy=0, start=0, ready=1, no done pulse. A fresh accept of 0x01 then produces a clean full frame.
- en asserted while busy (not in last stop cycle) with different data_in -> ignored; the current frame is unchanged and no extra frame is sent.
